nand_cmd_addr_seq: RTL and testbench
====================================

Name: nand_cmd_addr_seq

Overview:
- Command/address sequencer directly upstream of the NAND pin interface of mkFlashController.
- Accepts one request: first command byte, 0-5 address bytes, optional second command byte. Drives CEN/CLE/ALE/WRN/DQ with programmable cycle timing, waits tWB, then pulses done.
- Frees the controller FSM from per-cycle pin sequencing for READ, PROGRAM, ERASE and RESET.

Parameters:
- T_CS, 4, cycles CE# low before the first byte (legal 1-255)
- T_BYTE, 2, cycles each cmd/addr byte is held with CLE or ALE high (legal 1-255)
- T_CAD, 3, idle cycles after each byte, CLE=ALE=0 (legal 1-255)
- T_WB, 10, cycles CE# held low after the last gap before done (legal 1-255)

Ports:
- CLK  input  1  single clock, all state on rising edge
- RST_N  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  high only in IDLE (combinational from state)
- req_chip  input  1  target die; selects cen bit
- req_cmd1  input  8  first command byte
- req_naddr  input  3  number of address bytes; values above 5 clamp to 5
- req_addr  input  40  address bytes, byte 0 = [7:0], sent first
- req_has_cmd2  input  1  send req_cmd2 after the address bytes
- req_cmd2  input  8  second command byte
- cen  output  2  chip enables, active low
- cle  output  1  command latch enable
- ale  output  1  address latch enable
- wrn  output  1  W/R#, held 1 (write direction) throughout
- dq_out  output  8  byte driven to pads
- dq_oe  output  1  pad output enable
- busy  output  1  state != IDLE
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, immediate): state IDLE; cen=2'b11, cle=0, ale=0, wrn=1, dq_out=0, dq_oe=0, busy=0, done=0, all counters 0. Reset mid-operation aborts with no done pulse. req_ready is high from the first cycle after RST_N deasserts.
- Accept: req_valid & req_ready at edge E0. At E0 all request fields are latched; later input changes are ignored until the next accept.
- States: IDLE -> CE_SETUP -> BYTE -> GAP -> (BYTE | WAIT_WB) ... -> DONE -> IDLE.
- Byte list, fixed order: cmd1; then addr bytes 0..n-1; then cmd2 if has_cmd2. nbytes = 1 + min(naddr,5) + has_cmd2.
- CE_SETUP, T_CS cycles: cen[req_chip]=0, other bit 1; cle=ale=0; dq_oe=0.
- BYTE, T_BYTE cycles:
  - dq_out = current byte, dq_oe=1.
  - cle=1 for command bytes, ale=1 for address bytes; never both high.
- GAP, T_CAD cycles: cle=ale=0, dq_oe=0, dq_out holds the last byte. Then go to BYTE if bytes remain, else WAIT_WB.
- WAIT_WB, T_WB cycles: CE# stays low; cle=ale=dq_oe=0.
- DONE, one cycle: done=1, cen=2'b11, req_ready=0. Next cycle: IDLE, ready=1.
- Timing: done is high in the cycle starting T_CS + nbytes*(T_BYTE+T_CAD) + T_WB edges after E0.
- Back-to-back: a request waiting during DONE is accepted at the first IDLE edge, giving one idle cycle with cen=2'b11 between operations.
- All outputs are registered except req_ready and busy. No combinational path from req_* to the pad outputs.
- Duration counters are 8 bits and compare against (T_x - 1); byte index counter is 3 bits.

Test Plan:
- Reset check: RST_N=0 -> cen=11, wrn=1, cle=ale=dq_oe=done=0; RST_N=1 -> req_ready=1 next cycle.
- RESET cmd (defaults): cmd1=FF, naddr=0, has_cmd2=0, chip=0 -> cen=10 from E0; cle=1, dq=FF in cycles 5-6; done exactly 19 cycles after E0; cen=11 in that cycle.
- READ: chip=1, cmd1=00, naddr=5, addr=40'hEF_BE_AD_DE_01, cmd2=30 ->
  - byte order 00,01,DE,AD,BE,EF,30; ale high only on the 5 address bytes; cen=01.
  - done at cycle 49.
- Clamp and ignore: naddr=7 -> exactly 5 ale bytes. req_valid held high while busy -> req_ready=0, no second accept. Request fields changed mid-op -> sent bytes unchanged.
- Back-to-back: req_valid held continuously -> second accept on the cycle after done; one idle cycle with cen=11 between operations.
- Abort: RST_N pulsed low during the third byte -> outputs return to reset values immediately, no done pulse; a new request then completes normally.

Source files
------------

// File: rtl/nand_cmd_addr_seq.sv
// NAND command/address pin sequencer: walks cmd1, up to five address bytes and
// an optional cmd2 onto the pads with programmable setup/hold/gap/tWB timing.
module nand_cmd_addr_seq #(
  parameter int T_CS   = 4,
  parameter int T_BYTE = 2,
  parameter int T_CAD  = 3,
  parameter int T_WB   = 10
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_chip,
  input  logic [7:0]  req_cmd1,
  input  logic [2:0]  req_naddr,
  input  logic [39:0] req_addr,
  input  logic        req_has_cmd2,
  input  logic [7:0]  req_cmd2,
  output logic [1:0]  cen,
  output logic        cle,
  output logic        ale,
  output logic        wrn,
  output logic [7:0]  dq_out,
  output logic        dq_oe,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CE_SETUP, S_BYTE, S_GAP, S_WAIT_WB, S_DONE
  } state_t;

  localparam logic [7:0] CS_LAST   = 8'(T_CS - 1);
  localparam logic [7:0] BYTE_LAST = 8'(T_BYTE - 1);
  localparam logic [7:0] CAD_LAST  = 8'(T_CAD - 1);
  localparam logic [7:0] WB_LAST   = 8'(T_WB - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        chip_q, chip_d;
  logic [7:0]  cmd1_q, cmd1_d;
  logic [2:0]  naddr_q, naddr_d;
  logic [39:0] addr_q, addr_d;
  logic        has2_q, has2_d;
  logic [7:0]  cmd2_q, cmd2_d;
  logic [2:0]  last_idx_q;

  logic [1:0]  cen_q, cen_d;
  logic        cle_q, cle_d;
  logic        ale_q, ale_d;
  logic [7:0]  dq_q, dq_d;
  logic        oe_q, oe_d;
  logic        done_q, done_d;

  // Index of the final byte in the list (cmd1 is index 0).
  assign last_idx_q = naddr_q + {2'b00, has2_q};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      chip_q  <= 1'b0;
      cmd1_q  <= '0;
      naddr_q <= '0;
      addr_q  <= '0;
      has2_q  <= 1'b0;
      cmd2_q  <= '0;
      cen_q   <= 2'b11;
      cle_q   <= 1'b0;
      ale_q   <= 1'b0;
      dq_q    <= '0;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      chip_q  <= chip_d;
      cmd1_q  <= cmd1_d;
      naddr_q <= naddr_d;
      addr_q  <= addr_d;
      has2_q  <= has2_d;
      cmd2_q  <= cmd2_d;
      cen_q   <= cen_d;
      cle_q   <= cle_d;
      ale_q   <= ale_d;
      dq_q    <= dq_d;
      oe_q    <= oe_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    chip_d  = chip_q;
    cmd1_d  = cmd1_q;
    naddr_d = naddr_q;
    addr_d  = addr_q;
    has2_d  = has2_q;
    cmd2_d  = cmd2_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (req_valid) begin
          state_d = S_CE_SETUP;
          chip_d  = req_chip;
          cmd1_d  = req_cmd1;
          naddr_d = (req_naddr > 3'd5) ? 3'd5 : req_naddr;
          addr_d  = req_addr;
          has2_d  = req_has_cmd2;
          cmd2_d  = req_cmd2;
        end
      end
      S_CE_SETUP: begin
        if (cnt_q == CS_LAST) begin
          state_d = S_BYTE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_BYTE: begin
        if (cnt_q == BYTE_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == CAD_LAST) begin
          cnt_d = '0;
          if (idx_q == last_idx_q) begin
            state_d = S_WAIT_WB;
          end else begin
            state_d = S_BYTE;
            idx_d   = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WAIT_WB: begin
        if (cnt_q == WB_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pad outputs are decoded from the next state so they land in flops and
  // line up with the state they describe.
  logic [2:0]  last_idx_d;
  logic [2:0]  aidx;
  logic [39:0] addr_sh;
  logic        is_cmd;
  logic [7:0]  cur_byte;
  logic [1:0]  cen_active;

  always_comb begin
    last_idx_d = naddr_d + {2'b00, has2_d};
    aidx       = idx_d - 3'd1;
    addr_sh    = addr_d >> {aidx, 3'b000};
    is_cmd     = (idx_d == 3'd0) || (has2_d && (idx_d == last_idx_d));
    if (idx_d == 3'd0) begin
      cur_byte = cmd1_d;
    end else if (is_cmd) begin
      cur_byte = cmd2_d;
    end else begin
      cur_byte = addr_sh[7:0];
    end
    cen_active = chip_d ? 2'b01 : 2'b10;

    cen_d  = 2'b11;
    cle_d  = 1'b0;
    ale_d  = 1'b0;
    dq_d   = dq_q;
    oe_d   = 1'b0;
    done_d = 1'b0;
    case (state_d)
      S_CE_SETUP, S_GAP, S_WAIT_WB: cen_d = cen_active;
      S_BYTE: begin
        cen_d = cen_active;
        dq_d  = cur_byte;
        oe_d  = 1'b1;
        cle_d = is_cmd;
        ale_d = !is_cmd;
      end
      S_DONE:  done_d = 1'b1;
      default: cen_d = 2'b11;
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign wrn       = 1'b1;
  assign cen       = cen_q;
  assign cle       = cle_q;
  assign ale       = ale_q;
  assign dq_out    = dq_q;
  assign dq_oe     = oe_q;
  assign done      = done_q;

endmodule

// File: tb/tb_nand_cmd_addr_seq.sv
// Bench for nand_cmd_addr_seq: per-cycle expected pin timeline built from the
// byte list at each accept, plus directed literal checks and random traffic.
module tb_nand_cmd_addr_seq;
  localparam int T_CS = 4, T_BYTE = 2, T_CAD = 3, T_WB = 10;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_chip = 1'b0;
  logic [7:0]  req_cmd1 = '0;
  logic [2:0]  req_naddr = '0;
  logic [39:0] req_addr = '0;
  logic        req_has_cmd2 = 1'b0;
  logic [7:0]  req_cmd2 = '0;
  logic [1:0]  cen;
  logic        cle, ale, wrn, dq_oe, busy, done;
  logic [7:0]  dq_out;

  nand_cmd_addr_seq #(.T_CS(T_CS), .T_BYTE(T_BYTE), .T_CAD(T_CAD), .T_WB(T_WB)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_chip(req_chip),
    .req_cmd1(req_cmd1), .req_naddr(req_naddr), .req_addr(req_addr),
    .req_has_cmd2(req_has_cmd2), .req_cmd2(req_cmd2),
    .cen(cen), .cle(cle), .ale(ale), .wrn(wrn), .dq_out(dq_out), .dq_oe(dq_oe),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0] cen;
    logic       cle;
    logic       ale;
    logic       oe;
    logic [7:0] dq;
    logic       dq_chk;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   model_ready = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expand one request into the exact pin picture of every cycle until done.
  task automatic build_expect();
    logic [7:0] bl[$];
    bit         cmdl[$];
    int         na;
    logic [1:0] ca;
    exp_t       e;
    ca = req_chip ? 2'b01 : 2'b10;
    na = (req_naddr > 3'd5) ? 5 : int'(req_naddr);
    bl.push_back(req_cmd1); cmdl.push_back(1'b1);
    for (int i = 0; i < na; i++) begin
      bl.push_back(8'(req_addr >> (8 * i)));
      cmdl.push_back(1'b0);
    end
    if (req_has_cmd2) begin
      bl.push_back(req_cmd2); cmdl.push_back(1'b1);
    end
    repeat (T_CS) begin
      e = '0; e.cen = ca; exp_q.push_back(e);
    end
    for (int i = 0; i < bl.size(); i++) begin
      repeat (T_BYTE) begin
        e = '0; e.cen = ca; e.cle = cmdl[i]; e.ale = !cmdl[i];
        e.oe = 1'b1; e.dq = bl[i]; e.dq_chk = 1'b1;
        exp_q.push_back(e);
      end
      repeat (T_CAD) begin
        e = '0; e.cen = ca; e.dq = bl[i]; e.dq_chk = 1'b1;
        exp_q.push_back(e);
      end
    end
    repeat (T_WB) begin
      e = '0; e.cen = ca; exp_q.push_back(e);
    end
    e = '0; e.cen = 2'b11; e.done = 1'b1;
    exp_q.push_back(e);
  endtask

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) exp_q.delete();
    else if (model_ready && req_valid) build_expect();
  end

  always @(negedge CLK) begin
    exp_t e;
    if (!RST_N) begin
      check("reset_outputs", {cen, cle, ale, wrn, dq_oe, done, busy, dq_out},
            {2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
      model_ready = 1'b1;
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      model_ready = 1'b0;
      check("cycle_pins", {cen, cle, ale, wrn, dq_oe, done, busy, req_ready},
            {e.cen, e.cle, e.ale, 1'b1, e.oe, e.done, 1'b1, 1'b0});
      if (e.dq_chk) check("cycle_dq", dq_out, e.dq);
    end else begin
      check("idle_pins", {cen, cle, ale, wrn, dq_oe, done, busy, req_ready},
            {2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
      model_ready = 1'b1;
    end
  end

  logic [7:0] cap_b[8];
  logic       cap_ale[8];
  logic       cap_cle[8];
  int         cap_n, cap_nale, cap_done_k, cap_first_k;
  logic [1:0] cap_cen0, cap_cen_done;

  task automatic wait_ready();
    int t;
    t = 0;
    @(negedge CLK);
    while (!req_ready && t < 300) begin
      @(negedge CLK);
      t++;
    end
    if (!req_ready) check("wait_ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic set_req(input logic chip, input logic [7:0] c1, input logic [2:0] na,
                         input logic [39:0] ad, input logic h2, input logic [7:0] c2);
    req_chip = chip; req_cmd1 = c1; req_naddr = na;
    req_addr = ad; req_has_cmd2 = h2; req_cmd2 = c2;
  endtask

  task automatic run_op(input logic chip, input logic [7:0] c1, input logic [2:0] na,
                        input logic [39:0] ad, input logic h2, input logic [7:0] c2,
                        input bit scramble, input bit hold);
    logic prev_oe;
    wait_ready();
    set_req(chip, c1, na, ad, h2, c2);
    req_valid = 1'b1;
    @(posedge CLK);
    #2;
    if (!scramble && !hold) req_valid = 1'b0;
    cap_n = 0; cap_nale = 0; cap_done_k = -1; cap_first_k = -1; prev_oe = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      if (k == 0) cap_cen0 = cen;
      if (dq_oe && !prev_oe && cap_n < 8) begin
        cap_b[cap_n] = dq_out; cap_ale[cap_n] = ale; cap_cle[cap_n] = cle;
        if (ale) cap_nale++;
        if (cap_first_k < 0) cap_first_k = k;
        cap_n++;
      end
      prev_oe = dq_oe;
      if (done) begin
        cap_done_k = k;
        cap_cen_done = cen;
        break;
      end
      if (scramble) set_req(1'($urandom), 8'($urandom), 3'($urandom),
                            40'({$urandom, $urandom}), 1'($urandom), 8'($urandom));
    end
    if (scramble && !hold) req_valid = 1'b0;
    if (cap_done_k < 0) check("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    check("ready_after_reset", req_ready, 1'b1);

    run_op(1'b0, 8'hFF, 3'd0, 40'h0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("reset_cmd_done_cycle", cap_done_k, 19);
    check("reset_cmd_nbytes", cap_n, 1);
    check("reset_cmd_byte", {cap_cle[0], cap_b[0]}, {1'b1, 8'hFF});
    check("reset_cmd_first_byte_cycle", cap_first_k, 4);
    check("reset_cmd_cen_start", cap_cen0, 2'b10);
    check("reset_cmd_cen_at_done", cap_cen_done, 2'b11);

    run_op(1'b1, 8'h00, 3'd5, 40'hEF_BE_AD_DE_01, 1'b1, 8'h30, 1'b0, 1'b0);
    check("read_done_cycle", cap_done_k, 49);
    check("read_byte_order", {cap_b[0], cap_b[1], cap_b[2], cap_b[3], cap_b[4], cap_b[5], cap_b[6]},
          56'h00_01_DE_AD_BE_EF_30);
    check("read_ale_mask", {cap_ale[0], cap_ale[1], cap_ale[2], cap_ale[3], cap_ale[4], cap_ale[5], cap_ale[6]},
          7'b0111110);
    check("read_cen", cap_cen0, 2'b01);

    run_op(1'b0, 8'h60, 3'd7, 40'h11_22_33_44_55, 1'b0, 8'hD0, 1'b1, 1'b0);
    check("clamp_ale_bytes", cap_nale, 5);
    check("clamp_nbytes", cap_n, 6);
    check("clamp_done_cycle", cap_done_k, 44);
    check("clamp_bytes_unchanged", {cap_b[0], cap_b[1], cap_b[2], cap_b[3], cap_b[4], cap_b[5]},
          48'h60_55_44_33_22_11);

    run_op(1'b1, 8'h70, 3'd0, 40'h0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge CLK);
    check("b2b_idle_gap", {busy, req_ready, cen}, {1'b0, 1'b1, 2'b11});
    @(negedge CLK);
    check("b2b_second_accept", {busy, cen}, {1'b1, 2'b01});
    req_valid = 1'b0;

    wait_ready();
    set_req(1'b1, 8'h00, 3'd5, 40'hEF_BE_AD_DE_01, 1'b1, 8'h30);
    req_valid = 1'b1;
    @(posedge CLK);
    #2 req_valid = 1'b0;
    repeat (15) @(negedge CLK);
    check("abort_third_byte", {ale, dq_oe, dq_out}, {1'b1, 1'b1, 8'hDE});
    #1 RST_N = 1'b0;
    #1 check("abort_immediate", {cen, cle, ale, dq_oe, dq_out, done, busy},
             {2'b11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    repeat (2) @(negedge CLK);
    #1 RST_N = 1'b1;
    run_op(1'b0, 8'hFF, 3'd0, 40'h0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("after_abort_done_cycle", cap_done_k, 19);

    for (int c = 0; c < 2500; c++) begin
      @(posedge CLK);
      #2;
      req_valid = ($urandom_range(0, 3) == 0);
      set_req(1'($urandom), 8'($urandom), 3'($urandom),
              40'({$urandom, $urandom}), 1'($urandom), 8'($urandom));
    end
    req_valid = 1'b0;
    wait_ready();
    repeat (3) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
